// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO owner: single-cycle multiply/move, 32-step restoring divide
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        hilo_we,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] rq;
  logic [31:0] divisor;
  logic [31:0] a_raw;
  logic        q_sign;
  logic        r_sign;
  logic        dbz;

  logic        is_div;
  logic        is_sdiv;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_sub;
  logic [63:0] rq_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_sdiv = (funct == F_DIV);
  assign is_div  = is_sdiv || (funct == F_DIVU);
  assign abs_a   = (is_sdiv && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign abs_b   = (is_sdiv && src_b[31]) ? (~src_b + 32'd1) : src_b;

  assign prod_s = $signed(src_a) * $signed(src_b);
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Partial remainder after the shift; the trial difference always fits 32 bits when kept.
  assign rem_sh  = {rq[63:32], rq[31]};
  assign fits    = (rem_sh >= {1'b0, divisor});
  assign rem_sub = rem_sh[31:0] - divisor;
  assign rq_step = fits ? {rem_sub, rq[30:0], 1'b1} : {rem_sh[31:0], rq[30:0], 1'b0};

  assign quo_fix = q_sign ? (~rq[31:0] + 32'd1) : rq[31:0];
  assign rem_fix = r_sign ? (~rq[63:32] + 32'd1) : rq[63:32];

  assign stall = ((state == S_IDLE) && hilo_we && is_div && !flush) ||
                 ((state == S_BUSY) && !flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= 5'd0;
      rq      <= 64'd0;
      divisor <= 32'd0;
      a_raw   <= 32'd0;
      q_sign  <= 1'b0;
      r_sign  <= 1'b0;
      dbz     <= 1'b0;
      hi_o    <= 32'd0;
      lo_o    <= 32'd0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (hilo_we) begin
            case (funct)
              F_MULT:  {hi_o, lo_o} <= prod_s;
              F_MULTU: {hi_o, lo_o} <= prod_u;
              F_MTHI:  hi_o <= src_a;
              F_MTLO:  lo_o <= src_a;
              F_DIV, F_DIVU: begin
                rq      <= {32'd0, abs_a};
                divisor <= abs_b;
                a_raw   <= src_a;
                q_sign  <= is_sdiv && (src_a[31] ^ src_b[31]);
                r_sign  <= is_sdiv && src_a[31];
                dbz     <= (src_b == 32'd0);
                count   <= 5'd0;
                state   <= S_BUSY;
              end
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          rq    <= rq_step;
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_DONE;
        end
        S_DONE: begin
          // The held divide instruction is ignored here so it cannot restart.
          if (dbz) begin
            hi_o <= a_raw;
            lo_o <= 32'hFFFF_FFFF;
          end else begin
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Execute-stage multiply/divide unit that owns the HI/LO architectural registers. It consumes the `hilo_we` qualifier and function code that the main decoder produces for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiplies and moves complete in one cycle. Divides run a 32-iteration radix-2 restoring divider and stall the pipeline until HI/LO are written.

## Interface
Parameters: none (fixed 32-bit datapath).

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `hilo_we`  in  1  EX-stage instruction writes HI/LO (decoder output, pipelined to EX)
- `funct`  in  6  EX-stage `instr[5:0]`: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011
- `src_a`  in  32  rs operand, post-forwarding
- `src_b`  in  32  rt operand, post-forwarding
- `flush`  in  1  cancel the EX instruction and any divide in progress
- `stall`  out  1  hold IF/ID/EX while a divide is outstanding
- `hi_o`  out  32  registered HI value
- `lo_o`  out  32  registered LO value

## Operation
- **Reset:** `hi_o`=0, `lo_o`=0, FSM=IDLE, `stall`=0. All internal counters and operand registers are cleared.
- **Flush priority:** while `flush`=1, no HI/LO write occurs and no divide is accepted. The FSM goes to IDLE.
- **Single-cycle operations.** These take effect only in IDLE, with `hilo_we`=1 and `flush`=0.
  - MULT: {HI,LO} ← signed 64-bit product of `src_a` and `src_b`.
  - MULTU: {HI,LO} ← unsigned 64-bit product.
  - MTHI: HI ← `src_a`; LO is unchanged.
  - MTLO: LO ← `src_a`; HI is unchanged.
  - Any other `funct` with `hilo_we`=1 causes no write.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE → BUSY:** on `hilo_we`=1, DIV or DIVU, and `flush`=0. The unit latches:
  - |a| and |b| (the raw values for DIVU);
  - quotient sign = a[31]^b[31] and remainder sign = a[31] (DIV only);
  - a divide-by-zero flag (b==0).
  - The counter is set to 0.
- **BUSY:** one restoring step per cycle.
  - Shift the {rem,quo} 64-bit register left by 1.
  - Trial-subtract the divisor from the upper 33 bits. If the result is non-negative, keep it and set the quotient LSB.
  - The counter increments. After 32 steps (count 31 completing) the FSM goes to DONE.
- **DONE:** HI ← remainder and LO ← quotient, sign-fixed.
  - The quotient is negated if the quotient sign is set; the remainder is negated if the remainder sign is set.
  - Truncation is toward zero.
  - The FSM then returns to IDLE unconditionally.
  - Inputs are ignored in DONE. The held DIV instruction is still present on `hilo_we`/`funct` and must not restart.
- **Divide by zero:** LO=0xFFFFFFFF and HI=`src_a` as latched; no sign fixup. Duration is identical to a normal divide.
- **Overflow case:** 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- **Stall:** `stall` = (IDLE & `hilo_we` & DIV/DIVU & ~`flush`) | BUSY. It is combinational and deasserted in DONE.
- **No bypass:** `hi_o`/`lo_o` reflect registered state only. Same-cycle MTHI→MFHI bypass is the forwarding unit's job.

## Timing
- MULT/MULTU/MTHI/MTLO in cycle T: new HI/LO are visible on `hi_o`/`lo_o` from T+1. `stall` stays 0.
- DIV accepted in cycle T (IDLE):
  - `stall`=1 in T through T+32 (33 cycles).
  - BUSY spans T+1..T+32; DONE is T+33 with `stall`=0.
  - HI/LO are written at the end of T+33 and visible from T+34.
- A new DIV presented in T+34 is accepted; back-to-back divides are spaced 34 cycles apart.
- **Flush in BUSY or DONE:** FSM is IDLE the next cycle, HI/LO are unchanged, and `stall` drops in the flush cycle.
- **Reset mid-divide:** same as flush, and HI/LO are also zeroed.
- **Multiplier:** combinational 32×32 → 64 feeding the HI/LO registers; a single-cycle path is required.

## Test plan
- MULT `src_a`=0xFFFFFFFD (−3), `src_b`=5 → next cycle `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFF1; `stall` never asserts.
- MULTU 0xFFFFFFFF×2 → `hi_o`=0x00000001, `lo_o`=0xFFFFFFFE. Then MTHI 0x12345678 → `hi_o`=0x12345678 with `lo_o` unchanged. Then MTLO 0xCAFEBABE → `lo_o`=0xCAFEBABE.
- DIV −7/2, with `hilo_we`/`funct` held while `stall`=1 → `stall` high for exactly 33 cycles; then `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF. No second divide starts.
- DIVU 100/7 → `lo_o`=14, `hi_o`=2.
- DIVU 0x55/0 → after 34 cycles `lo_o`=0xFFFFFFFF, `hi_o`=0x00000055.
- DIV 0x80000000/0xFFFFFFFF with `flush` pulsed in BUSY cycle 10 → `stall` 0 in the flush cycle, HI/LO keep their prior values, FSM IDLE. Re-issue without flush → `lo_o`=0x80000000, `hi_o`=0.
